// File: rtl/mult_acc_pkg.sv
// mult_acc_pkg: types and constants shared by the product accumulator.
//   state_t      - frame FSM states (ACCUM collects beats, HOLD presents a result)
//   COUNT_WIDTH  - width of the per-frame beat counter
//   sat_bound()  - clamp limit for a given accumulator width and mode, as a bit
//                  pattern in the low acc_width bits of a 64-bit word
package mult_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int COUNT_WIDTH = 16;

    // upper=1 gives the positive limit, upper=0 the negative limit.
    // Signed min is returned as its two's complement pattern (10...0).
    // Unsigned min is 0; it is never a clamp target because products are non-negative.
    function automatic logic [63:0] sat_bound(input int acc_width, input logic is_signed,
                                              input logic upper);
        logic [63:0] one;
        one = 64'd1;
        if (is_signed) begin
            return upper ? ((one << (acc_width - 1)) - one) : (one << (acc_width - 1));
        end
        return upper ? ((one << acc_width) - one) : 64'd0;
    endfunction

endpackage

// File: rtl/mult_accumulator_sat_adder.sv
// sat_adder: combinational add of one multiplier product into the running sum.
//   base      - running sum (zero on the first beat of a frame)
//   product   - 2*WIDTH-bit product, sign- or zero-extended per is_signed
//   is_signed - frame mode
//   result    - next running sum, clamped (SATURATE=1) or wrapped (SATURATE=0)
//   overflow  - the true sum did not fit in ACC_WIDTH bits for this mode
module sat_adder
    import mult_acc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2 * WIDTH + 8,
    parameter bit SATURATE  = 1'b1
) (
    input  logic [ACC_WIDTH-1:0] base,
    input  logic [2*WIDTH-1:0]   product,
    input  logic                 is_signed,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 overflow
);

    localparam int PAD = ACC_WIDTH + 1 - 2 * WIDTH;

    localparam logic [ACC_WIDTH-1:0] S_MAX = ACC_WIDTH'(sat_bound(ACC_WIDTH, 1'b1, 1'b1));
    localparam logic [ACC_WIDTH-1:0] S_MIN = ACC_WIDTH'(sat_bound(ACC_WIDTH, 1'b1, 1'b0));
    localparam logic [ACC_WIDTH-1:0] U_MAX = ACC_WIDTH'(sat_bound(ACC_WIDTH, 1'b0, 1'b1));

    logic [ACC_WIDTH:0] prod_ext;
    logic [ACC_WIDTH:0] base_ext;
    logic [ACC_WIDTH:0] sum;

    always_comb begin
        // One extra bit holds any sum of two in-range operands exactly.
        prod_ext = {{PAD{is_signed & product[2*WIDTH-1]}}, product};
        base_ext = {is_signed & base[ACC_WIDTH-1], base};
        sum      = base_ext + prod_ext;

        // Signed: the top two bits disagree when the value left the ACC_WIDTH range.
        if (is_signed) begin
            overflow = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        end else begin
            overflow = sum[ACC_WIDTH];
        end

        result = sum[ACC_WIDTH-1:0];
        if (overflow && SATURATE) begin
            if (!is_signed) begin
                result = U_MAX;
            end else if (sum[ACC_WIDTH]) begin
                result = S_MIN;   // true sum is negative
            end else begin
                result = S_MAX;
            end
        end
    end

endmodule

// File: rtl/mult_accumulator.sv
// mult_accumulator: sums multiplier products over a frame and presents the result.
//   in_valid/in_ready/in_product/in_signed/in_last - product beat input
//   out_valid/out_ready                            - frame result output
//   out_acc      - frame sum (ACC_WIDTH bits)
//   out_count    - accepted beats in the frame, saturating at all-ones
//   out_overflow - any add in the frame overflowed
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid does not depend on ready on either port.
module mult_accumulator
    import mult_acc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2 * WIDTH + 8,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*WIDTH-1:0]     in_product,
    input  logic                   in_signed,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_acc,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_overflow
);

    state_t state;
    state_t next_state;

    logic [ACC_WIDTH-1:0]   acc;
    logic [COUNT_WIDTH-1:0] count;
    logic                   overflow;
    logic                   in_frame;      // at least one beat of the current frame taken
    logic                   frame_signed;

    logic                   beat;
    logic                   out_fire;
    logic                   beat_signed;
    logic [ACC_WIDTH-1:0]   base;
    logic [ACC_WIDTH-1:0]   sum;
    logic                   add_ovf;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   ovf_next;

    sat_adder #(
        .WIDTH    (WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .SATURATE (SATURATE)
    ) u_sat_adder (
        .base     (base),
        .product  (in_product),
        .is_signed(beat_signed),
        .result   (sum),
        .overflow (add_ovf)
    );

    always_comb begin
        in_ready    = (state == ACCUM) && !rst;
        out_valid   = (state == HOLD);
        beat        = in_valid && in_ready;
        out_fire    = out_valid && out_ready;
        // Mode is latched from the first beat; later in_signed values are ignored.
        beat_signed = in_frame ? frame_signed : in_signed;
        base        = in_frame ? acc : '0;
        count_next  = (&count) ? count : count + COUNT_WIDTH'(1);
        ovf_next    = overflow | add_ovf;

        next_state = state;
        case (state)
            ACCUM:   if (beat && in_last) next_state = HOLD;
            HOLD:    if (out_fire)        next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            acc          <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            in_frame     <= 1'b0;
            frame_signed <= 1'b0;
            out_acc      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            state <= next_state;
            if (beat) begin
                acc      <= sum;
                count    <= count_next;
                overflow <= ovf_next;
                in_frame <= 1'b1;
                if (!in_frame) frame_signed <= in_signed;
                if (in_last) begin
                    out_acc      <= sum;
                    out_count    <= count_next;
                    out_overflow <= ovf_next;
                end
            end else if (out_fire) begin
                acc      <= '0;
                count    <= '0;
                overflow <= 1'b0;
                in_frame <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_accumulator.sv
module tb_mult_accumulator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_signed, in_last, out_ready;
    logic [15:0] in_product;

    logic        in_ready_a, in_ready_b, in_ready_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [23:0] out_acc_a;
    logic [16:0] out_acc_b, out_acc_c;
    logic [15:0] out_count_a, out_count_b, out_count_c;
    logic        out_ovf_a, out_ovf_b, out_ovf_c;

    // a: default 24-bit saturating; b: 17-bit saturating; c: 17-bit wrapping
    mult_accumulator #(.WIDTH(8)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_product(in_product), .in_signed(in_signed), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
        .out_count(out_count_a), .out_overflow(out_ovf_a));

    mult_accumulator #(.WIDTH(8), .ACC_WIDTH(17), .SATURATE(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_product(in_product), .in_signed(in_signed), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
        .out_count(out_count_b), .out_overflow(out_ovf_b));

    mult_accumulator #(.WIDTH(8), .ACC_WIDTH(17), .SATURATE(1'b0)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_product(in_product), .in_signed(in_signed), .in_last(in_last),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_acc(out_acc_c),
        .out_count(out_count_c), .out_overflow(out_ovf_c));

    int checks = 0;
    int errors = 0;

    logic [15:0] beats_q[$];
    bit          frame_sgn;

    logic [31:0] obs_acc_a, obs_acc_b, obs_acc_c, obs_cnt_a;
    logic        obs_ovf_a, obs_ovf_b, obs_ovf_c;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Frame result from plain integer arithmetic on the beats in beats_q.
    function automatic void model(input int w, input bit sat,
                                  output logic [31:0] acc_o, output logic ovf_o);
        longint acc, v, sum, m, lo, hi;
        bit ovf;
        acc = 0;
        ovf = 1'b0;
        m = longint'(1) << w;
        if (frame_sgn) begin
            lo = -(m / 2);
            hi = m / 2 - 1;
        end else begin
            lo = 0;
            hi = m - 1;
        end
        foreach (beats_q[i]) begin
            v   = frame_sgn ? longint'(shortint'(beats_q[i])) : longint'(beats_q[i]);
            sum = acc + v;
            if (sum < lo || sum > hi) begin
                ovf = 1'b1;
                if (sat) begin
                    acc = (sum < lo) ? lo : hi;
                end else begin
                    acc = ((sum % m) + m) % m;
                    if (acc > hi) acc -= m;
                end
            end else begin
                acc = sum;
            end
        end
        acc_o = 32'(acc & (m - 1));
        ovf_o = ovf;
    endfunction

    function automatic logic [15:0] rand_product();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Drives beats_q as one frame, checks the result, holds it hold_cycles, then hands it off.
    task automatic run_frame(input bit gaps, input int hold_cycles);
        int          idx, cyc, n, exp_cnt;
        bit          take, first_checked;
        logic [31:0] ea, eb, ec;
        logic        oa, ob, oc;
        idx = 0;
        cyc = 0;
        n = beats_q.size();
        first_checked = 1'b0;
        while (idx < n) begin
            @(negedge clk);
            out_ready = 1'($urandom);   // must be ignored while no result is pending
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid   = 1'b0;
                in_product = 16'($urandom);
                in_last    = 1'($urandom);
                in_signed  = 1'($urandom);
            end else begin
                in_valid   = 1'b1;
                in_product = beats_q[idx];
                in_signed  = (idx == 0) ? frame_sgn : ~frame_sgn;
                in_last    = (idx == n - 1);
            end
            if (!first_checked && in_valid) begin
                check("in_ready_frame_start", 32'(in_ready_a), 32'd1);
                first_checked = 1'b1;
            end
            take = in_valid && in_ready_a;
            if (take && idx == n - 1) check("out_valid_low_in_frame", 32'(out_valid_a), 32'd0);
            @(posedge clk);
            if (take) idx++;
            cyc++;
            if (cyc > 4 * n + 100) begin
                check("frame_timeout", 32'(idx), 32'(n));
                break;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        check("latency_out_valid_a", 32'(out_valid_a), 32'd1);
        check("latency_out_valid_b", 32'(out_valid_b), 32'd1);
        check("latency_out_valid_c", 32'(out_valid_c), 32'd1);
        model(24, 1'b1, ea, oa);
        model(17, 1'b1, eb, ob);
        model(17, 1'b0, ec, oc);
        exp_cnt = (n > 65535) ? 65535 : n;
        check("acc_a", 32'(out_acc_a), ea);
        check("ovf_a", 32'(out_ovf_a), 32'(oa));
        check("count_a", 32'(out_count_a), 32'(exp_cnt));
        check("acc_b_sat17", 32'(out_acc_b), eb);
        check("ovf_b_sat17", 32'(out_ovf_b), 32'(ob));
        check("acc_c_wrap17", 32'(out_acc_c), ec);
        check("ovf_c_wrap17", 32'(out_ovf_c), 32'(oc));
        check("count_c", 32'(out_count_c), 32'(exp_cnt));
        obs_acc_a = 32'(out_acc_a);
        obs_acc_b = 32'(out_acc_b);
        obs_acc_c = 32'(out_acc_c);
        obs_cnt_a = 32'(out_count_a);
        obs_ovf_a = out_ovf_a;
        obs_ovf_b = out_ovf_b;
        obs_ovf_c = out_ovf_c;
        for (int i = 0; i < hold_cycles; i++) begin
            in_valid   = 1'b1;
            in_product = 16'($urandom);
            in_last    = 1'($urandom);
            out_ready  = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid_a), 32'd1);
            check("hold_in_ready", 32'(in_ready_a), 32'd0);
            check("hold_acc_stable", 32'(out_acc_a), obs_acc_a);
            check("hold_count_stable", 32'(out_count_a), obs_cnt_a);
        end
        in_valid   = 1'b1;
        in_last    = 1'b1;
        in_product = 16'($urandom);
        out_ready  = 1'b1;
        check("handshake_in_ready_low", 32'(in_ready_a), 32'd0);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        check("after_hs_out_valid", 32'(out_valid_a), 32'd0);
        check("after_hs_in_ready", 32'(in_ready_a), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_signed  = 1'b0;
        in_last    = 1'b0;
        in_product = 16'h0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready_a), 32'd0);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_out_acc", 32'(out_acc_a), 32'd0);
        check("rst_out_count", 32'(out_count_a), 32'd0);
        check("rst_out_ovf", 32'(out_ovf_a), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready_a), 32'd1);

        // Unsigned sum
        beats_q = {};
        beats_q.push_back(16'h1000);
        beats_q.push_back(16'h2000);
        beats_q.push_back(16'h0001);
        frame_sgn = 1'b0;
        run_frame(1'b0, 0);
        check("plan_unsigned_acc", obs_acc_a, 32'h003001);
        check("plan_unsigned_cnt", obs_cnt_a, 32'd3);
        check("plan_unsigned_ovf", 32'(obs_ovf_a), 32'd0);

        // Signed sum; the later beat drives in_signed=0
        beats_q = {};
        beats_q.push_back(16'hFFFE);
        beats_q.push_back(16'h0005);
        frame_sgn = 1'b1;
        run_frame(1'b0, 1);
        check("plan_signed_latch_acc", obs_acc_a, 32'h000003);

        // Saturation / wrap at 17 bits
        beats_q = {};
        repeat (3) beats_q.push_back(16'h7FFF);
        frame_sgn = 1'b1;
        run_frame(1'b0, 0);
        check("plan_sat17_acc", obs_acc_b, 32'h0FFFF);
        check("plan_sat17_ovf", 32'(obs_ovf_b), 32'd1);
        check("plan_wrap17_acc", obs_acc_c, 32'h17FFD);
        check("plan_wrap17_ovf", 32'(obs_ovf_c), 32'd1);
        check("plan_acc24_no_ovf", 32'(obs_ovf_a), 32'd0);

        // Backpressure: result held 5 cycles with in_valid high
        beats_q = {};
        repeat (4) beats_q.push_back(rand_product());
        frame_sgn = 1'($urandom);
        run_frame(1'b1, 5);

        // Reset mid-frame: 2 beats of a 4-beat frame, then reset
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_product = 16'h1234;
            in_signed  = 1'b0;
            in_last    = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid_a), 32'd0);
        check("midrst_in_ready", 32'(in_ready_a), 32'd0);
        rst = 1'b0;
        beats_q = {};
        beats_q.push_back(16'h0042);
        frame_sgn = 1'b0;
        run_frame(1'b0, 0);
        check("plan_midrst_acc", obs_acc_a, 32'h000042);
        check("plan_midrst_cnt", obs_cnt_a, 32'd1);

        // Random frames
        for (int f = 0; f < 20; f++) begin
            beats_q = {};
            repeat ($urandom_range(1, 8)) beats_q.push_back(rand_product());
            frame_sgn = 1'($urandom);
            run_frame(1'b1, $urandom_range(0, 3));
        end

        // Count saturation
        beats_q = {};
        repeat (65540) beats_q.push_back(16'h0001);
        frame_sgn = 1'b0;
        run_frame(1'b0, 0);
        check("plan_count_sat_cnt", obs_cnt_a, 32'h0000FFFF);
        check("plan_count_sat_acc", obs_acc_a, 32'd65540);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
